// File: rtl/alu_exec_unit.sv
// Single-issue ALU execute stage. Logic ops, ADD and SUB finish in one edge.
// Shifts by n > 0 step one bit per cycle, so they take n+1 edges.
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  operation,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: an operation transfers on an edge with in_valid && in_ready,
    // and a result transfers on an edge with out_valid && out_ready. A flush
    // or reset on that edge overrides both transfers.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;

    state_t      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  sop_q, sop_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;

    logic        accept;
    logic [31:0] single_res;
    logic [31:0] shifted;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Shift codes reach this path only with shamt 0, so they pass A through.
    function automatic logic [31:0] alu_single(input logic [3:0] op,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        logic [31:0] r;
        case (op)
            OP_AND:                 r = x & y;
            OP_OR:                  r = x | y;
            OP_ADD:                 r = x + y;
            OP_XOR:                 r = x ^ y;
            OP_SUB:                 r = x - y;
            OP_SLL, OP_SRL, OP_SRA: r = x;
            default:                r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] shift_one(input logic [3:0] op,
                                              input logic [31:0] w);
        logic [31:0] r;
        case (op)
            OP_SLL:  r = {w[30:0], 1'b0};
            OP_SRL:  r = {1'b0, w[31:1]};
            default: r = {w[31], w[31:1]};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= 32'd0;
            cnt_q    <= 5'd0;
            sop_q    <= 4'd0;
            result_q <= 32'd0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            sop_q    <= sop_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        sop_d      = sop_q;
        result_d   = result_q;
        zero_d     = zero_q;
        accept     = in_valid && in_ready && !flush;
        single_res = alu_single(operation, a, b);
        shifted    = shift_one(sop_q, work_q);

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    work_d = shifted;
                    cnt_d  = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d  = ST_DONE;
                        result_d = shifted;
                        zero_d   = (shifted == 32'd0);
                    end
                end
                ST_DONE: begin
                    if (out_ready && !accept) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase

            // Acceptance happens only in IDLE or DONE. It overrides the DONE
            // drain so that back-to-back operations issue one per cycle.
            if (accept) begin
                if (is_shift(operation) && (b[4:0] != 5'd0)) begin
                    state_d = ST_SHIFT;
                    work_d  = a;
                    cnt_d   = b[4:0];
                    sop_d   = operation;
                end else begin
                    state_d  = ST_DONE;
                    result_d = single_res;
                    zero_d   = (single_res == 32'd0);
                end
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        busy      = (state_q == ST_SHIFT);
        out_valid = (state_q == ST_DONE);
        result    = result_q;
        zero      = zero_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases plus random operations,
// scored against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic        zero, busy;
    logic [3:0]  operation;
    logic [31:0] a, b, result;
    logic [1:0]  dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;

    alu_exec_unit dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .operation(operation), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] x,
                                               input logic [31:0] y);
        int sh;
        sh = int'(y % 32);
        case (op)
            4'd0:    return x & y;
            4'd1:    return x | y;
            4'd2:    return x + y;
            4'd3:    return x ^ y;
            4'd4:    return x << sh;
            4'd5:    return x >> sh;
            4'd6:    return x - y;
            4'd7:    return $unsigned($signed(x) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] y);
        if ((op == 4'd4 || op == 4'd5 || op == 4'd7) && (y % 32) != 0)
            return int'(y % 32) + 1;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, wait for its result, optionally stall the consumer.
    task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input int hold, input string tag);
        int          exp_lat, edges, busy_cnt, rdy_busy;
        logic [31:0] exp_r;
        exp_lat = ref_latency(op, bv);
        exp_q.push_back(ref_result(op, av, bv));
        out_ready = 1'b1;
        operation = op; a = av; b = bv; in_valid = 1'b1;
        #1;
        check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid  = 1'b0;
        operation = 4'($urandom_range(15, 0));
        a = $urandom;
        b = $urandom;
        out_ready = (hold == 0);
        edges = 1; busy_cnt = 0; rdy_busy = 0;
        while (!out_valid && edges < 40) begin
            if (busy) busy_cnt++;
            if (busy && in_ready) rdy_busy++;
            tick();
            edges++;
        end
        exp_r = exp_q.pop_front();
        last_exp = exp_r;
        check({tag, ".latency"}, edges, exp_lat);
        check({tag, ".busy_cycles"}, busy_cnt, exp_lat - 1);
        check({tag, ".ready_in_shift"}, rdy_busy, 0);
        check({tag, ".result"}, result, exp_r);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_r == 32'd0});
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ".hold_result"}, result, exp_r);
            check({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, ".hold_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        int          ov_seen;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        operation = 4'd0; a = 32'd0; b = 32'd0; last_exp = 32'd0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.zero", {31'd0, zero}, 32'd1);

        run_op(4'd2, 32'hFFFF_FFFF, 32'd1, 0, "add_wrap");
        check("add_wrap.value", last_exp, 32'd0);
        run_op(4'd6, 32'd5, 32'd7, 0, "sub_neg");
        check("sub_neg.value", last_exp, 32'hFFFF_FFFE);
        run_op(4'd7, 32'h8000_0000, 32'd31, 0, "sra31");
        check("sra31.value", last_exp, 32'hFFFF_FFFF);
        run_op(4'd5, 32'h8000_0000, 32'd31, 0, "srl31");
        check("srl31.value", last_exp, 32'h0000_0001);
        run_op(4'd4, 32'h1, 32'h20, 0, "sll_sh0");
        run_op(4'd3, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 3, "xor_bp");
        check("xor_bp.value", last_exp, 32'h0F0F_0F0F);
        run_op(4'd0, 32'hC, 32'hA, 0, "and_b2b");
        check("and_b2b.value", last_exp, 32'h8);
        run_op(4'd1, 32'h5, 32'hA, 0, "or_b2b");

        // Flush on the third cycle of a 10-bit shift.
        tick();
        operation = 4'd4; a = 32'd1; b = 32'd10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush.busy", {31'd0, busy}, 32'd0);
        check("flush.out_valid", {31'd0, out_valid}, 32'd0);
        check("flush.in_ready", {31'd0, in_ready}, 32'd1);
        check("flush.result_kept", result, last_exp);
        ov_seen = 0;
        repeat (12) begin
            tick();
            if (out_valid) ov_seen++;
        end
        check("flush.no_valid", ov_seen, 0);
        run_op(4'd1, 32'h1, 32'h2, 0, "or_after_flush");
        check("or_after_flush.value", last_exp, 32'h3);

        // Flush wins over a simultaneous operation in IDLE.
        tick();
        flush = 1'b1; in_valid = 1'b1; operation = 4'd2; a = 32'd9; b = 32'd9;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_win.out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_win.busy", {31'd0, busy}, 32'd0);
        check("flush_win.result", result, last_exp);

        // Reset in the middle of a 20-bit SRL.
        operation = 4'd5; a = 32'hDEAD_BEEF; b = 32'd20; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("midshift.busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst.result", result, 32'd0);
        check("midrst.zero", {31'd0, zero}, 32'd1);
        check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst.busy", {31'd0, busy}, 32'd0);
        check("midrst.in_ready", {31'd0, in_ready}, 32'd1);
        run_op(4'd9, 32'h1234_5678, 32'h9, 0, "reserved9");

        for (int k = 0; k < 60; k++) begin
            rop = 4'($urandom_range(15, 0));
            if (k % 3 == 0) rop = 4'($urandom_range(7, 4));
            ra = $urandom;
            rb = $urandom;
            if (k % 5 == 0) ra = rb;
            run_op(rop, ra, rb, int'($urandom_range(3, 0)), $sformatf("rnd%0d", k));
        end

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
